// File: rtl/neuron_pkg.sv
// neuron_pkg: shared types and helpers for the multi-lane neuron.
// Holds FSM state encoding, activation modes, saturating add, tree width.
package neuron_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_BIAS,
    S_ACT,
    S_DONE
  } state_e;

  localparam int ACT_RELU  = 0;
  localparam int ACT_LEAKY = 1;

  // Width of a LANES-wide sum of 2*dw products.
  function automatic int tree_w(input int dw, input int lanes);
    return 2 * dw + $clog2(lanes);
  endfunction

  // Signed add clamped to the w-bit signed range (w <= 62).
  function automatic logic [63:0] sat_add(
    input logic [63:0] a,
    input logic [63:0] b,
    input int          w
  );
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = $signed(a) + $signed(b);
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/neuron_if.sv
// neuron_if: input beat stream, config bus and result stream of a neuron.
// master = upstream/config driver, slave = the neuron.
interface neuron_if #(
  parameter int DW    = 16,
  parameter int LANES = 4
);
  logic [LANES*DW-1:0] in_data;
  logic                in_valid;
  logic                in_ready;
  logic                weight_valid;
  logic                bias_valid;
  logic [31:0]         weight_value;
  logic [31:0]         bias_value;
  logic [31:0]         config_layer_num;
  logic [31:0]         config_neuron_num;
  logic [DW-1:0]       out_data;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output in_data, in_valid,
    input  in_ready,
    output weight_valid, bias_valid,
    output weight_value, bias_value,
    output config_layer_num, config_neuron_num,
    input  out_data, out_valid,
    output out_ready
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready,
    input  weight_valid, bias_valid,
    input  weight_value, bias_value,
    input  config_layer_num, config_neuron_num,
    output out_data, out_valid,
    input  out_ready
  );
endinterface

// File: rtl/neuron_wbank.sv
// neuron_wbank: one lane's weight store, 1 write port, 1 registered read.
// Ports: clk, rst_n, we/waddr/wdata write, raddr in, rdata out.
module neuron_wbank #(
  parameter int DW    = 16,
  parameter int DEPTH = 196,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Storage has no reset so weights survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/neuron_par.sv
// neuron_par: LANES-wide MAC neuron, saturating acc, bias, ReLU (leaky when
// NEURON_LEAKY_EN). Ports: clk, rst_n, bus (neuron_if.slave: in/config/out).
module neuron_par
  import neuron_pkg::*;
#(
  parameter int LAYER_NO         = 0,
  parameter int NEURON_NO        = 0,
  parameter int NUM_WEIGHT       = 784,
  parameter int DATA_WIDTH       = 16,
  parameter int LANES            = 4,
  parameter int WEIGHT_INT_WIDTH = 1
) (
  input logic     clk,
  input logic     rst_n,
  neuron_if.slave bus
);

  localparam int DW    = DATA_WIDTH;
  localparam int WIW   = WEIGHT_INT_WIDTH;
  localparam int BEATS = (NUM_WEIGHT + LANES - 1) / LANES;
  localparam int AW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;
  localparam int ACC_W = 2 * DW;
  localparam int TW    = tree_w(DW, LANES);

`ifdef NEURON_LEAKY_EN
  localparam int ACT_MODE = ACT_LEAKY;
`else
  localparam int ACT_MODE = ACT_RELU;
`endif

  localparam logic [2:0] ST_IDLE  = S_IDLE;
  localparam logic [2:0] ST_ACCUM = S_ACCUM;
  localparam logic [2:0] ST_BIAS  = S_BIAS;
  localparam logic [2:0] ST_ACT   = S_ACT;
  localparam logic [2:0] ST_DONE  = S_DONE;

  logic [2:0]             state;
  logic [ACC_W-1:0]       acc;
  logic [AW-1:0]          beat;
  logic [PW-1:0]          wptr;
  logic [DW-1:0]          bias_q;
  logic                   rdy_q;
  logic                   vld_q;
  logic [DW-1:0]          out_q;
  logic                   s1_vld, s1_last;
  logic                   s2_vld, s2_last;
  logic                   id_ok, w_we, accept, last_beat;
  logic [LANES-1:0]       w_en;
  logic [AW-1:0]          waddr;
  logic [LANES*ACC_W-1:0] prod_v;
  logic signed [TW-1:0]   tree;
  logic [ACC_W-1:0]       acc_sum, acc_bias;
  logic [DW-1:0]          act_out;
  logic signed [ACC_W-1:0] nshr;
  logic [63:0]            t_sum, t_bias;
  logic                   unused_hi;

  assign unused_hi = ^{bus.weight_value[31:DW], bus.bias_value[31:DW]};

  assign id_ok = (bus.config_layer_num == 32'(LAYER_NO)) &&
                 (bus.config_neuron_num == 32'(NEURON_NO));
  assign w_we  = bus.weight_valid && id_ok;
  assign waddr = AW'(32'(wptr) / LANES);

  assign accept    = bus.in_valid && rdy_q;
  assign last_beat = (beat == AW'(BEATS - 1));

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = vld_q;
  assign bus.out_data  = out_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    // Lanes past NUM_WEIGHT on the final beat are zeroed.
    localparam bit PAD = ((BEATS - 1) * LANES + l) >= NUM_WEIGHT;
    logic [DW-1:0]    w_q;
    logic [DW-1:0]    x_q;
    logic [ACC_W-1:0] p_q;

    assign w_en[l] = w_we && ((32'(wptr) % LANES) == l);

    neuron_wbank #(
      .DW    (DW),
      .DEPTH (BEATS),
      .AW    (AW)
    ) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (w_en[l]),
      .waddr (waddr),
      .wdata (bus.weight_value[DW-1:0]),
      .raddr (beat),
      .rdata (w_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        x_q <= '0;
        p_q <= '0;
      end else begin
        if (accept)
          x_q <= (PAD && last_beat) ? '0 : bus.in_data[l*DW +: DW];
        p_q <= ACC_W'($signed(x_q)) * ACC_W'($signed(w_q));
      end
    end

    assign prod_v[l*ACC_W +: ACC_W] = p_q;
  end

  always_comb begin
    tree = '0;
    for (int l = 0; l < LANES; l++)
      tree = tree + TW'($signed(prod_v[l*ACC_W +: ACC_W]));
  end

  always_comb begin
    t_sum    = sat_add(64'($signed(acc)), 64'($signed(tree)), ACC_W);
    t_bias   = sat_add(64'($signed(acc)),
                       64'($signed({bias_q, DW'(0)})), ACC_W);
    acc_sum  = t_sum[ACC_W-1:0];
    acc_bias = t_bias[ACC_W-1:0];
  end

  // Output window is acc[ACC_W-1-WIW -: DW]; any set bit at or
  // above the window's sign position means the value does not fit.
  always_comb begin
    nshr = $signed(acc) >>> 3;
    if (!acc[ACC_W-1]) begin
      if (|acc[ACC_W-1 -: WIW+1])
        act_out = {1'b0, {(DW-1){1'b1}}};
      else
        act_out = acc[ACC_W-1-WIW -: DW];
    end else if (ACT_MODE == ACT_LEAKY) begin
      if (&nshr[ACC_W-1 -: WIW+1])
        act_out = nshr[ACC_W-1-WIW -: DW];
      else
        act_out = {1'b1, {(DW-1){1'b0}}};
    end else begin
      act_out = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr   <= '0;
      bias_q <= '0;
    end else begin
      if (w_we)
        wptr <= (wptr == PW'(NUM_WEIGHT - 1)) ? '0 : wptr + PW'(1);
      if (bus.bias_valid && id_ok)
        bias_q <= bus.bias_value[DW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      acc     <= '0;
      beat    <= '0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      out_q   <= '0;
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      s2_vld  <= 1'b0;
      s2_last <= 1'b0;
    end else begin
      s1_vld  <= accept;
      s1_last <= accept && last_beat;
      s2_vld  <= s1_vld;
      s2_last <= s1_last;
      if (accept)
        beat <= last_beat ? '0 : beat + AW'(1);
      if (s2_vld)
        acc <= acc_sum;
      if (accept && last_beat)
        rdy_q <= 1'b0;
      else if (state == ST_IDLE ||
               (state == ST_DONE && bus.out_ready))
        rdy_q <= 1'b1;
      unique case (state)
        ST_IDLE:
          if (accept) state <= ST_ACCUM;
        ST_ACCUM:
          if (s2_vld && s2_last) state <= ST_BIAS;
        ST_BIAS: begin
          acc   <= acc_bias;
          state <= ST_ACT;
        end
        ST_ACT: begin
          out_q <= act_out;
          vld_q <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE:
          if (bus.out_ready) begin
            vld_q <= 1'b0;
            acc   <= '0;
            beat  <= '0;
            state <= ST_IDLE;
          end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_par.sv
// tb_neuron_par: directed checks of neuron_par on three instances
// (8, 6 and 784 weights, 4 lanes) sharing one stimulus bus.
module tb_neuron_par;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        weight_valid = 1'b0;
  logic        bias_valid = 1'b0;
  logic [31:0] weight_value = '0;
  logic [31:0] bias_value = '0;
  logic [31:0] cfg_layer = '0;
  logic [31:0] cfg_neuron = '0;
  int          sel = 0;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] bq[$];

  logic        cur_rdy;
  logic        cur_ov;
  logic [15:0] cur_od;

  always #5 clk = ~clk;

  neuron_if #(.DW(16), .LANES(4)) ifa ();
  neuron_if #(.DW(16), .LANES(4)) ifb ();
  neuron_if #(.DW(16), .LANES(4)) ifc ();

  assign ifa.in_data = in_data;
  assign ifb.in_data = in_data;
  assign ifc.in_data = in_data;
  assign ifa.in_valid = in_valid && (sel == 0);
  assign ifb.in_valid = in_valid && (sel == 1);
  assign ifc.in_valid = in_valid && (sel == 2);
  assign ifa.out_ready = out_ready && (sel == 0);
  assign ifb.out_ready = out_ready && (sel == 1);
  assign ifc.out_ready = out_ready && (sel == 2);
  assign ifa.weight_valid = weight_valid;
  assign ifb.weight_valid = weight_valid;
  assign ifc.weight_valid = weight_valid;
  assign ifa.bias_valid = bias_valid;
  assign ifb.bias_valid = bias_valid;
  assign ifc.bias_valid = bias_valid;
  assign ifa.weight_value = weight_value;
  assign ifb.weight_value = weight_value;
  assign ifc.weight_value = weight_value;
  assign ifa.bias_value = bias_value;
  assign ifb.bias_value = bias_value;
  assign ifc.bias_value = bias_value;
  assign ifa.config_layer_num = cfg_layer;
  assign ifb.config_layer_num = cfg_layer;
  assign ifc.config_layer_num = cfg_layer;
  assign ifa.config_neuron_num = cfg_neuron;
  assign ifb.config_neuron_num = cfg_neuron;
  assign ifc.config_neuron_num = cfg_neuron;

  neuron_par #(.NEURON_NO(0), .NUM_WEIGHT(8)) u_a (
    .clk (clk), .rst_n (rst_n), .bus (ifa)
  );
  neuron_par #(.NEURON_NO(1), .NUM_WEIGHT(6)) u_b (
    .clk (clk), .rst_n (rst_n), .bus (ifb)
  );
  neuron_par #(.NEURON_NO(2), .NUM_WEIGHT(784)) u_c (
    .clk (clk), .rst_n (rst_n), .bus (ifc)
  );

  always_comb begin
    case (sel)
      0: begin
        cur_rdy = ifa.in_ready;
        cur_ov  = ifa.out_valid;
        cur_od  = ifa.out_data;
      end
      1: begin
        cur_rdy = ifb.in_ready;
        cur_ov  = ifb.out_valid;
        cur_od  = ifb.out_data;
      end
      default: begin
        cur_rdy = ifc.in_ready;
        cur_ov  = ifc.out_valid;
        cur_od  = ifc.out_data;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_w(input int layer, input int neuron,
                      input logic [15:0] v);
    cfg_layer    = 32'(layer);
    cfg_neuron   = 32'(neuron);
    weight_value = {16'hDEAD, v};
    weight_valid = 1'b1;
    tick();
    weight_valid = 1'b0;
  endtask

  task automatic wr_b(input int neuron, input logic [15:0] v);
    cfg_layer  = '0;
    cfg_neuron = 32'(neuron);
    bias_value = {16'hBEEF, v};
    bias_valid = 1'b1;
    tick();
    bias_valid = 1'b0;
  endtask

  task automatic send(input int bubble);
    int t;
    for (int i = 0; i < bq.size(); i++) begin
      in_data  = bq[i];
      in_valid = 1'b1;
      t = 0;
      while (!cur_rdy && t < 200) begin
        tick();
        t++;
      end
      if (t == 200) chk("rdy_timeout", {31'd0, cur_rdy}, 32'd1);
      tick();
      in_valid = 1'b0;
      if (bubble != 0 && i != bq.size() - 1) tick();
    end
    bq.delete();
  endtask

  task automatic infer(input string tag, input logic [15:0] exp,
                       input int bubble, input int stall);
    int lat;
    send(bubble);
    lat = 1;
    while (!cur_ov && lat < 3000) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd5);
    chk({tag, "_data"}, {16'd0, cur_od}, {16'd0, exp});
    for (int k = 0; k < stall; k++) begin
      tick();
      chk({tag, "_stall_vld"}, {31'd0, cur_ov}, 32'd1);
      chk({tag, "_stall_data"}, {16'd0, cur_od}, {16'd0, exp});
      chk({tag, "_stall_rdy"}, {31'd0, cur_rdy}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_vld_clr"}, {31'd0, cur_ov}, 32'd0);
    tick();
    chk({tag, "_rdy_back"}, {31'd0, cur_rdy}, 32'd1);
  endtask

  initial begin
    logic [15:0] neg_b, neg_c;
`ifdef NEURON_LEAKY_EN
    neg_b = 16'hFFFB;
    neg_c = 16'hE000;
`else
    neg_b = 16'h0000;
    neg_c = 16'h0000;
`endif
    repeat (3) tick();
    chk("rst_vld", {31'd0, ifa.out_valid}, 32'd0);
    chk("rst_data", {16'd0, ifa.out_data}, 32'd0);
    chk("rst_rdy", {31'd0, ifa.in_ready}, 32'd0);
    rst_n = 1'b1;
    chk("rel_rdy0", {31'd0, ifa.in_ready}, 32'd0);
    tick();
    chk("rel_rdy1", {31'd0, ifa.in_ready}, 32'd1);

    // A: w0=0x0200 later overwritten by the 9th (wrapping) write.
    wr_w(0, 0, 16'h0200);
    wr_w(0, 5, 16'h7FFF);
    wr_w(1, 0, 16'h7FFF);
    for (int i = 0; i < 8; i++) wr_w(0, 0, 16'h0100);
    sel = 0;
    bq.push_back(64'h0100_0100_0100_0100);
    bq.push_back(64'h0100_0100_0100_0100);
    infer("a_basic", 16'h0010, 0, 0);

    bq.push_back(64'h0100_0100_0100_0100);
    bq.push_back(64'h0100_0100_0100_0100);
    infer("a_stall", 16'h0010, 0, 10);
    bq.push_back(64'h0200_0200_0200_0200);
    bq.push_back(64'h0080_0080_0080_0080);
    infer("a_gap", 16'h0014, 1, 0);

    // Reset in the middle of an inference.
    bq.push_back(64'h7FFF_7FFF_7FFF_7FFF);
    send(0);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", {31'd0, ifa.out_valid}, 32'd0);
    chk("mid_rst_data", {16'd0, ifa.out_data}, 32'd0);
    chk("mid_rst_rdy", {31'd0, ifa.in_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    bq.push_back(64'h0100_0100_0100_0100);
    bq.push_back(64'h0100_0100_0100_0100);
    infer("a_rerun", 16'h0010, 0, 0);

    // B: 6 weights over 2 beats, lanes 2-3 of beat 2 are padding.
    for (int i = 1; i <= 6; i++) wr_w(0, 1, 16'(i * 256));
    wr_b(1, 16'h0001);
    wr_b(7, 16'h4000);
    sel = 1;
    bq.push_back(64'h0100_0100_0100_0100);
    bq.push_back(64'h7FFF_7FFF_0100_0100);
    infer("b_pos", 16'h002C, 0, 0);
    bq.push_back(64'hFF00_FF00_FF00_FF00);
    bq.push_back(64'h7FFF_7FFF_FF00_FF00);
    infer("b_neg", neg_b, 1, 0);

    // C: 784 full-scale weights, saturating accumulation.
    for (int i = 0; i < 784; i++) wr_w(0, 2, 16'h7FFF);
    wr_w(0, 3, 16'h0000);
    sel = 2;
    for (int i = 0; i < 196; i++) bq.push_back(64'h7FFF_7FFF_7FFF_7FFF);
    infer("c_sat_pos", 16'h7FFF, 0, 0);
    for (int i = 0; i < 196; i++) bq.push_back(64'h8001_8001_8001_8001);
    infer("c_sat_neg", neg_c, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
